// File: rtl/gcd_pkg.sv
// Shared types and defaults for the iterative GCD engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gcd_pkg;

    // Controller states: IDLE waits for start, CALC performs one subtract per clock.
    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } gcd_state_e;

    localparam int GCD_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/gcd_datapath.sv
// X/Y operand registers with one shared subtractor (larger minus smaller).
// Latency: load and step take effect on the next rising edge of clk.
// Backpressure: none; the controller decides when to load or step.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset (X=Y=0)
//   load, ld_x, ld_y  : load X/Y with ld_x/ld_y (takes priority over step)
//   step              : replace the larger register with larger - smaller
//   eq, gt, zero      : X==Y, X>Y (unsigned), X==0 || Y==0
//   x_val, y_val      : current register contents
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] ld_x,
    input  logic [WIDTH-1:0] ld_y,
    output logic             eq,
    output logic             gt,
    output logic             zero,
    output logic [WIDTH-1:0] x_val,
    output logic [WIDTH-1:0] y_val
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic [WIDTH-1:0] diff;

    assign eq    = (x_q == y_q);
    assign gt    = (x_q > y_q);
    assign zero  = (x_q == '0) || (y_q == '0);
    assign x_val = x_q;
    assign y_val = y_q;

    // Operand-select muxes feed a single subtractor so it always computes
    // larger - smaller and can never wrap.
    assign minuend    = gt ? x_q : y_q;
    assign subtrahend = gt ? y_q : x_q;
    assign diff       = minuend - subtrahend;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = ld_x;
            y_d = ld_y;
        end else if (step) begin
            if (gt) begin
                x_d = diff;
            end else begin
                y_d = diff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD by repeated subtraction with start/busy/done handshake.
// Latency: done pulses S+1 cycles after the start edge (S = subtractions).
// Backpressure: start is ignored while busy; no queueing.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset (aborts, no done)
//   start, a, b: request and operands, sampled only while busy=0
//   busy       : computation in progress
//   done       : one-cycle pulse, q/err valid from this cycle and held
//   q, err     : unsigned GCD magnitude; err set when both operands are zero
// Build option: GCD_SIGNED_IN_EN treats a/b as two's complement and loads
// their magnitudes; otherwise a/b load unchanged.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             err
);

    gcd_state_e       state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             err_q, err_d;

    logic             load;
    logic             step;
    logic [WIDTH-1:0] ld_x;
    logic [WIDTH-1:0] ld_y;
    logic             eq;
    logic             gt;
    logic             zero;
    logic [WIDTH-1:0] x_val;
    logic [WIDTH-1:0] y_val;

`ifdef GCD_SIGNED_IN_EN
    // Two's-complement magnitude. The most-negative value negates to itself,
    // which read unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign ld_x = mag(a);
    assign ld_y = mag(b);
`else
    assign ld_x = a;
    assign ld_y = b;
`endif

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .ld_x  (ld_x),
        .ld_y  (ld_y),
        .eq    (eq),
        .gt    (gt),
        .zero  (zero),
        .x_val (x_val),
        .y_val (y_val)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        q_d     = q_q;
        err_d   = err_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (zero) begin
                    // One operand zero: the other is the answer (0 when both are).
                    q_d     = x_val | y_val;
                    err_d   = ~|(x_val | y_val);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (eq) begin
                    q_d     = x_val;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    // busy falls on the same edge that raises done.
    assign busy = (state_q == CALC);
    assign done = done_q;
    assign q    = q_q;
    assign err  = err_q;

endmodule

// File: tb/tb_gcd_engine.sv
module tb_gcd_engine;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic         err;

    int   total;
    int   bad;
    exp_t sb[$];
    logic prev_done;

    gcd_engine #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: magnitude of the operand as the build interprets it.
    function automatic int ref_mag(input logic [W-1:0] v);
        int s;
`ifdef GCD_SIGNED_IN_EN
        s = v[W-1] ? int'(v) - (1 << W) : int'(v);
`else
        s = int'(v);
`endif
        return (s < 0) ? -s : s;
    endfunction

    // Reference: Euclid with remainders.
    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (prev_done) chk("done_one_cycle", 1, 0);
            chk("busy_low_at_done", int'(busy), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("q", int'(q), int'(e.q));
                chk("err", int'(err), int'(e.err));
            end
        end
        prev_done <= done;
    end

    // Issue one operation (called #1 after a rising edge). exp_lat/exp_busy < 0
    // skips those checks; inj >= 0 raises a stray start(9,6) that many cycles in.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int exp_lat, input int exp_busy, input int inj);
        exp_t e;
        int   m1;
        int   m2;
        int   n;
        int   bc;
        m1    = ref_mag(ta);
        m2    = ref_mag(tb_v);
        e.q   = W'(ref_gcd(m1, m2));
        e.err = (m1 == 0) && (m2 == 0);
        sb.push_back(e);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        n     = 0;
        bc    = 0;
        while (!done && n < 400) begin
            if (busy) bc++;
            start = (inj >= 0 && n == inj);
            if (start) begin
                a = W'(9);
                b = W'(6);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        if (!done) begin
            chk("timeout", n, 0);
            void'(sb.pop_back());
        end else begin
            if (exp_lat >= 0) chk("latency", n, exp_lat);
            if (exp_busy >= 0) chk("busy_cycles", bc, exp_busy);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        prev_done = 1'b0;
        reset     = 1'b1;
        start     = 1'b1;
        a         = W'(12);
        b         = W'(8);

        // Reset held two cycles with start asserted: must stay idle.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_rst", int'(busy), 0);

        run_op(W'(12), W'(8), 3, 3, -1);
        // q must hold after the done pulse.
        repeat (3) @(posedge clk);
        #1;
        chk("q_hold", int'(q), 4);

        run_op(W'(0), W'(0), 1, 1, -1);
        run_op(W'(0), W'(6), 1, 1, -1);
`ifdef GCD_SIGNED_IN_EN
        run_op(W'(8'hF4), W'(8), -1, -1, -1);
        run_op(W'(8'h80), W'(64), 2, 2, -1);
`else
        run_op(W'(8'hF4), W'(8), -1, -1, -1);
`endif
        // Worst case with a start(9,6) arriving mid-computation.
        run_op(W'(255), W'(1), 255, 255, 20);

        // Back-to-back random operations, including zero operands.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 3) ra = '0;
            if (i % 8 == 5) rb = '0;
            run_op(ra, rb, -1, -1, -1);
        end

        // Reset mid-computation: no done, outputs cleared.
        start = 1'b1;
        a     = W'(255);
        b     = W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        chk("busy_before_abort", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(q), 0);
        chk("abort_err", int'(err), 0);
        repeat (300) @(posedge clk);
        #1;
        chk("abort_still_idle", int'(busy), 0);

        run_op(W'(9), W'(6), 3, 3, -1);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised iterative GCD unit: captures two operands on a `start` strobe and computes their greatest common divisor by repeated subtraction, one subtract per clock. It is the next generation of the fixed 4-bit register/mux/subtractor datapath. It adds:
- width parametrisation,
- a start/busy/done handshake,
- zero-operand handling,
- optional two's-complement inputs.

It sits as a slave compute block driven by a controller or testbench.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥ 2).
- `clk`  input  1  clock; all state changes on rising edge.
- `reset`  input  1  reset. One clock; reset is synchronous and active-high.
- `start`  input  1  request; sampled only when `busy`=0.
- `a`  input  WIDTH  operand A; sampled with `start`.
- `b`  input  WIDTH  operand B; sampled with `start`.
- `busy`  output  1  high while a computation is in progress.
- `done`  output  1  one-cycle pulse; `q`/`err` valid from this cycle on.
- `q`  output  WIDTH  unsigned GCD magnitude; holds until the next `done`.
- `err`  output  1  set with `done` when both operands are zero.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1.
- Reset values: state IDLE, `busy`=0, `done`=0, `q`=0, `err`=0, internal regs X=Y=0.
- IDLE with `start`=1:
  - X ← mag(a), Y ← mag(b).
  - Go to CALC; `busy`=1 next cycle.
- CALC, evaluated each cycle in priority order:
  - X==0 or Y==0: `q` ← X|Y; `err` ← (X==0 && Y==0); `done` ← 1; go to IDLE.
  - X==Y: `q` ← X; `err` ← 0; `done` ← 1; go to IDLE.
  - X>Y: X ← X−Y, Y holds.
  - X<Y: Y ← Y−X, X holds.
- Arithmetic:
  - X and Y are unsigned WIDTH-bit.
  - Subtraction never underflows, because only larger − smaller is performed.
  - The comparison is unsigned.
- mag():
  - With the signed feature, mag() is |v| in two's complement. The most-negative value 100…0 maps to 2^(WIDTH−1) and is representable unsigned.
  - Without the feature, mag() is v itself.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` in the same cycle `done` pulses is accepted: the state is already IDLE that cycle.
- `a` and `b` may change freely after the sampling edge.
- `reset` mid-computation aborts: all registers return to reset values and no `done` is issued.

## Timing
- Edge E0 samples `start` and loads X/Y.
- With S subtractions, `done`=1 and valid `q` appear after edge E0+S+1. `busy` is high from after E0 to after E0+S.
- Zero operand: S=0, so `done` follows edge E0+1.
- Worst-case latency is 2^WIDTH − 1 cycles (operands 2^WIDTH−1 and 1).
- `done` is registered and high exactly one cycle. `busy` falls in the same cycle `done` rises.
- Back-to-back: the earliest next `start` is the `done` cycle, which gives a one-cycle gap.

## Configuration
- `GCD_SIGNED_IN_EN`:
  - Defined: `a`/`b` are two's complement, and magnitudes are taken at load.
  - Undefined: `a`/`b` are unsigned and loaded directly, with no abs logic.
- `q` is unsigned in both builds.

## Structure
- Package `gcd_pkg`:
  - state enum (IDLE, CALC).
  - `GCD_DEFAULT_WIDTH`=8.
- Sub-module `gcd_datapath` (parameter `WIDTH`):
  - X/Y registers, compare, single shared subtractor, operand-select muxes.
  - Outputs `eq`, `gt`, `zero` flags.
- `gcd_engine` holds the FSM and output registers. mag() lives in the load path of `gcd_engine`.

## Test plan
- WIDTH=8, reset held 2 cycles -> `busy`=`done`=`q`=`err`=0; `start` during reset is ignored.
- a=12, b=8 -> `done` after E0+3 with `q`=4, `err`=0; `busy` high for exactly 3 cycles.
- a=0, b=0 -> `done` after E0+1, `q`=0, `err`=1. Then a=0, b=6 -> `q`=6, `err`=0.
- With `GCD_SIGNED_IN_EN`:
  - a=−12 (0xF4), b=8 -> `q`=4.
  - a=0x80 (−128), b=64 -> `q`=64.
- Without `GCD_SIGNED_IN_EN`: a=0xF4 (244), b=8 -> `q`=4.
- Control cases:
  - a=255, b=1 -> `q`=1 after 255 cycles.
  - `start` with a=9, b=6 while busy -> ignored.
  - `reset` at cycle 100 -> no `done`, outputs 0.
  - Next `start` with a=9, b=6 -> `q`=3.
